// File: rtl/hms_pkg.sv
// Shared types and limits for the HH:MM:SS timekeeper.
package hms_pkg;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/hms_field_cnt.sv
// Modulo field counter with preset; carry flags an increment at MAX.
module hms_field_cnt #(
  parameter int         W   = 6,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);

  assign carry = inc && (value == MAX);

  always_ff @(posedge clk) begin
    if (rst)        value <= '0;
    else if (load)  value <= load_val;
    else if (carry) value <= '0;
    else if (inc)   value <= value + 1'b1;
  end

endmodule

// File: rtl/hms_timekeeper.sv
// HH:MM:SS timekeeper: prescaler, CLOCK/SETUP control, validated preset,
// 12/24-hour output mapping.
module hms_timekeeper #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode_pls,
  input  logic       i_pos_pls,
  input  logic       i_inc_pls,
  input  logic       i_h12,
  input  logic       i_load,
  input  logic [4:0] i_load_hour,
  input  logic [5:0] i_load_min,
  input  logic [5:0] i_load_sec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_mode,
  output logic [2:0] o_sel,
  output logic       o_tick,
  output logic       o_day_hit,
  output logic       o_load_err
);
  import hms_pkg::*;

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] pre_q, pre_d;
  mode_e mode_q, mode_d;
  pos_e  pos_q, pos_d;
  logic [4:0] hour;
  logic load_ok, acc, is_clock, wrap;
  logic tick, mode_go, edit;
  logic sec_inc, min_inc, hour_inc;
  logic sec_co, min_co, hour_co, day;

  assign load_ok  = (i_load_hour <= HOUR_MAX) &&
                    (i_load_min <= MIN_MAX) &&
                    (i_load_sec <= SEC_MAX);
  assign acc      = i_load && load_ok;
  assign is_clock = (mode_q == MODE_CLOCK);
  assign wrap     = (pre_q == PW'(CLK_HZ - 1));

  // Tick is judged on the pre-toggle mode, so it survives a SETUP entry.
  assign tick    = !i_load && is_clock && wrap;
  assign mode_go = !i_load && i_mode_pls;
  assign edit    = !i_load && !i_mode_pls && !is_clock;

  assign sec_inc  = tick ||
                    (edit && i_inc_pls && pos_q == POS_SEC);
  assign min_inc  = (tick && sec_co) ||
                    (edit && i_inc_pls && pos_q == POS_MIN);
  assign hour_inc = (tick && sec_co && min_co) ||
                    (edit && i_inc_pls && pos_q == POS_HOUR);
  assign day      = tick && sec_co && min_co && hour_co;

  hms_field_cnt #(.W(6), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .load(acc),
    .load_val(i_load_sec), .value(o_sec), .carry(sec_co)
  );

  hms_field_cnt #(.W(6), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .load(acc),
    .load_val(i_load_min), .value(o_min), .carry(min_co)
  );

  hms_field_cnt #(.W(5), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .inc(hour_inc), .load(acc),
    .load_val(i_load_hour), .value(hour), .carry(hour_co)
  );

  always_comb begin
    pre_d = pre_q;
    if (i_load) begin
      if (acc && is_clock) pre_d = '0;
    end else if (!is_clock || i_mode_pls || wrap) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    if (mode_go) begin
      mode_d = is_clock ? MODE_SETUP : MODE_CLOCK;
      if (is_clock) pos_d = POS_SEC;
    end else if (edit && i_pos_pls) begin
      unique case (pos_q)
        POS_SEC: pos_d = POS_MIN;
        POS_MIN: pos_d = POS_HOUR;
        default: pos_d = POS_SEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      mode_q     <= MODE_CLOCK;
      pos_q      <= POS_SEC;
      o_tick     <= 1'b0;
      o_day_hit  <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      o_tick     <= tick;
      o_day_hit  <= day;
      o_load_err <= i_load && !load_ok;
    end
  end

  always_comb begin
    o_sel = 3'b000;
    if (!is_clock) begin
      unique case (1'b1)
        pos_q == POS_MIN:  o_sel = 3'b010;
        pos_q == POS_HOUR: o_sel = 3'b100;
        default:           o_sel = 3'b001;
      endcase
    end
  end

  always_comb begin
    o_hour = hour;
    if (i_h12) begin
      if (hour == 5'd0)       o_hour = 5'd12;
      else if (hour > 5'd12)  o_hour = hour - 5'd12;
    end
  end

  assign o_pm   = (hour >= 5'd12);
  assign o_mode = (mode_q == MODE_SETUP);

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed plus randomized bench for hms_timekeeper against a
// seconds-of-day reference model.
module tb_hms_timekeeper;

  localparam int HZ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_mode_pls = 1'b0;
  logic       i_pos_pls = 1'b0;
  logic       i_inc_pls = 1'b0;
  logic       i_h12 = 1'b0;
  logic       i_load = 1'b0;
  logic [4:0] i_load_hour = '0;
  logic [5:0] i_load_min = '0;
  logic [5:0] i_load_sec = '0;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic       o_pm, o_mode, o_tick, o_day_hit, o_load_err;
  logic [2:0] o_sel;

  int compared = 0;
  int mismatched = 0;

  // model: time as seconds of day, cycles since last tick, mode, field
  int t = 0;
  int ph = 0;
  bit md = 0;
  int pos = 0;
  bit e_tick = 0, e_day = 0, e_err = 0;

  hms_timekeeper #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst(rst),
    .i_mode_pls(i_mode_pls), .i_pos_pls(i_pos_pls),
    .i_inc_pls(i_inc_pls), .i_h12(i_h12), .i_load(i_load),
    .i_load_hour(i_load_hour), .i_load_min(i_load_min),
    .i_load_sec(i_load_sec),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_pm(o_pm),
    .o_mode(o_mode), .o_sel(o_sel), .o_tick(o_tick),
    .o_day_hit(o_day_hit), .o_load_err(o_load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic mstep();
    int h, m, s;
    bit tk;
    e_tick = 0; e_day = 0; e_err = 0;
    if (rst) begin
      t = 0; ph = 0; md = 0; pos = 0;
    end else if (i_load) begin
      if (i_load_hour <= 23 && i_load_min <= 59 && i_load_sec <= 59) begin
        t = i_load_hour * 3600 + i_load_min * 60 + i_load_sec;
        if (!md) ph = 0;
      end else begin
        e_err = 1;
      end
    end else begin
      tk = !md && ph == HZ - 1;
      if (tk) begin
        e_tick = 1;
        e_day = (t == 86399);
        t = (t + 1) % 86400;
      end
      ph = (tk || md || i_mode_pls) ? 0 : ph + 1;
      if (i_mode_pls) begin
        md = !md;
        if (md) pos = 0;
      end else if (md) begin
        if (i_inc_pls) begin
          h = t / 3600; m = (t / 60) % 60; s = t % 60;
          case (pos)
            0: s = (s + 1) % 60;
            1: m = (m + 1) % 60;
            default: h = (h + 1) % 24;
          endcase
          t = h * 3600 + m * 60 + s;
        end
        if (i_pos_pls) pos = (pos + 1) % 3;
      end
    end
  endtask

  task automatic check_all();
    int h, eh;
    h = t / 3600;
    eh = !i_h12 ? h : (h % 12 == 0 ? 12 : h % 12);
    chk("sec", o_sec, t % 60);
    chk("min", o_min, (t / 60) % 60);
    chk("hour", o_hour, eh);
    chk("pm", o_pm, h >= 12);
    chk("mode", o_mode, md);
    chk("sel", o_sel, md ? (1 << pos) : 0);
    chk("tick", o_tick, e_tick);
    chk("day_hit", o_day_hit, e_day);
    chk("load_err", o_load_err, e_err);
  endtask

  task automatic cyc();
    mstep();
    @(posedge clk);
    #1;
    i_mode_pls = 0; i_pos_pls = 0; i_inc_pls = 0; i_load = 0;
    check_all();
  endtask

  task automatic load(input int h, input int m, input int s);
    i_load = 1;
    i_load_hour = 5'(h); i_load_min = 6'(m); i_load_sec = 6'(s);
    cyc();
  endtask

  initial begin
    // reset state
    rst = 1;
    cyc();
    i_h12 = 1; #1;
    chk("rst_h12_hour", o_hour, 12);
    chk("rst_h12_pm", o_pm, 0);
    i_h12 = 0; #1;
    chk("rst_h24_hour", o_hour, 0);
    rst = 0;

    // free run: ticks every HZ cycles
    for (int i = 0; i < 16; i++) cyc();
    chk("run16_sec", o_sec, 4);

    // midnight rollover
    load(23, 59, 58);
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_mid_sec", o_sec, 59);
    for (int i = 0; i < 4; i++) cyc();
    chk("mid_day_hit", o_day_hit, 1);
    chk("mid_hour", o_hour, 0);
    i_h12 = 1; #1;
    chk("mid_h12", o_hour, 12);
    chk("mid_pm", o_pm, 0);
    i_h12 = 0;
    cyc();
    chk("day_hit_once", o_day_hit, 0);

    // rejected loads
    load(24, 0, 0);
    chk("err_h24", o_load_err, 1);
    load(10, 60, 0);
    chk("err_m60", o_load_err, 1);
    cyc();
    chk("err_once", o_load_err, 0);

    // setup editing
    load(0, 0, 0);
    i_mode_pls = 1; cyc();
    i_pos_pls = 1; cyc();
    i_pos_pls = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      i_inc_pls = 1; cyc();
    end
    chk("setup_hour", o_hour, 3);
    chk("setup_sel", o_sel, 3'b100);
    chk("setup_tick", o_tick, 0);
    i_pos_pls = 1; cyc();
    load(3, 0, 59);
    i_inc_pls = 1; cyc();
    chk("sec_wrap", o_sec, 0);
    chk("no_carry_min", o_min, 0);
    i_inc_pls = 1; i_pos_pls = 1; cyc();
    chk("inc_pre_adv_sec", o_sec, 1);
    chk("inc_pre_adv_sel", o_sel, 3'b010);

    // mode masks pos/inc
    i_mode_pls = 1; i_pos_pls = 1; i_inc_pls = 1; cyc();
    chk("mask_mode", o_mode, 0);
    chk("mask_sec", o_sec, 1);

    // tick coincident with SETUP entry
    for (int i = 0; i < HZ && ph != HZ - 1; i++) cyc();
    chk("ph_reached", ph, HZ - 1);
    i_mode_pls = 1; cyc();
    chk("entry_tick_sec", o_sec, 2);
    chk("entry_tick_mode", o_mode, 1);

    // reset from SETUP
    load(13, 45, 10);
    rst = 1; cyc(); rst = 0;
    chk("rst_setup_mode", o_mode, 0);
    chk("rst_setup_sel", o_sel, 0);
    for (int i = 0; i < HZ; i++) cyc();
    chk("rst_first_tick", o_tick, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 300) == 0;
      i_mode_pls = ($urandom % 25) == 0;
      i_pos_pls = ($urandom % 4) == 0;
      i_inc_pls = ($urandom % 3) == 0;
      if (($urandom % 12) == 0) i_h12 = ~i_h12;
      if (($urandom % 30) == 0) begin
        i_load = 1;
        i_load_hour = 5'($urandom_range(0, 27));
        i_load_min = 6'($urandom_range(0, 62));
        i_load_sec = 6'($urandom_range(0, 62));
        if (($urandom % 3) == 0) begin
          i_load_hour = 5'd23; i_load_min = 6'd59;
          i_load_sec = 6'($urandom_range(55, 59));
        end
      end
      cyc();
      rst = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hms_timekeeper.md
# hms_timekeeper

Single-clock-domain HH:MM:SS timekeeper. It replaces the ripple-clocked min/sec counter and controller pair with enable-driven field counters. It adds an hour field, runtime 12/24-hour output format, a three-position setup mode, a validated preset load and a day-rollover pulse. It sits between the debounced switch pulse logic and the digit-split/FND/LED-scan display path, and drives the display with binary field values.

## Interface
- CLK_HZ, 50_000_000, clock cycles per second tick; benches override with a small value, minimum 2.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_mode_pls  in  1  one-cycle pulse; toggles CLOCK/SETUP.
- i_pos_pls  in  1  one-cycle pulse; advances the setup field SEC→MIN→HOUR→SEC.
- i_inc_pls  in  1  one-cycle pulse; increments the selected field in SETUP.
- i_h12  in  1  level; 1 = 12-hour output format, 0 = 24-hour output format.
- i_load  in  1  one-cycle pulse; presets all three fields.
- i_load_hour / i_load_min / i_load_sec  in  5/6/6  preset values in 24-hour binary.
- o_sec / o_min  out  6/6  binary 0..59.
- o_hour  out  5  0..23 in 24-hour format; 1..12 in 12-hour format.
- o_pm  out  1  1 when internal hour ≥ 12, in either format.
- o_mode  out  1  0 = CLOCK, 1 = SETUP.
- o_sel  out  3  one-hot selected field {HOUR,MIN,SEC} in SETUP; 000 in CLOCK.
- o_tick  out  1  one-cycle pulse on each prescaler wrap.
- o_day_hit  out  1  one-cycle pulse on the 23:59:59→00:00:00 rollover in CLOCK mode.
- o_load_err  out  1  one-cycle pulse when a rejected load occurs.

## Operation
- Reset values:
  - Prescaler = 0, time = 00:00:00, mode = CLOCK, position = SEC.
  - All pulse outputs are 0.
  - o_hour = 0 in 24-hour format and 12 in 12-hour format; o_pm = 0.
- Prescaler:
  - Counts 0..CLK_HZ-1 in CLOCK mode; o_tick = 1 in the cycle the count equals CLK_HZ-1, then the count wraps to 0.
  - In SETUP the prescaler is held at 0 and o_tick stays 0.
- CLOCK mode, on o_tick:
  - sec increments.
  - sec 59→0 carries to min in the same cycle; min 59→0 carries to hour in the same cycle; hour 23→0 with both carries asserts o_day_hit.
- SETUP mode:
  - i_inc_pls increments only the selected field, modulo 60 for sec/min and modulo 24 for hour.
  - No carry is generated and o_day_hit is never asserted.
- i_pos_pls advances position in SETUP only and is ignored in CLOCK.
- Every entry into SETUP forces position = SEC.
- Priority per cycle is rst > i_load > i_mode_pls > (i_pos_pls, i_inc_pls, tick):
  - A mode pulse masks position and increment pulses in the same cycle.
  - A tick that coincides with a mode pulse entering SETUP is still applied, because the update uses the pre-toggle mode.
  - i_pos_pls and i_inc_pls together: the increment applies to the pre-advance field, then the position advances.
- Load:
  - Accepted only if hour ≤ 23, min ≤ 59 and sec ≤ 59. An accepted load writes all three fields.
  - In CLOCK mode an accepted load also clears the prescaler.
  - If any field is out of range, nothing is written and o_load_err pulses.
  - Mode and position are unaffected by a load, accepted or rejected.
- 12-hour mapping, combinational from the hour register: internal 0→12, 1..12→same value, 13..23→value − 12.

## Timing
- Every input pulse takes effect at the next rising edge. Field outputs are registered and update one cycle after the qualifying input.
- o_tick and o_day_hit are asserted in the same cycle that the resulting count change becomes visible on the field outputs.
- o_hour and o_pm follow i_h12 combinationally, with zero latency.
- After leaving SETUP, the first tick occurs CLK_HZ cycles later.
- rst asserted mid-count restores all reset values at the next edge, regardless of other inputs.

## Structure
- Package hms_pkg holds:
  - MODE_CLOCK/MODE_SETUP (1 bit).
  - POS_SEC/POS_MIN/POS_HOUR (2 bits).
  - SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
- Sub-module hms_field_cnt:
  - Parameters: width, modulo maximum.
  - Ports: inc enable, load enable, load value, carry-out (asserted when inc occurs at the maximum).
  - Instantiated three times.
- Prescaler, mode/position FSM, load validation and 12-hour mapping stay in the top.

## Test plan
- CLK_HZ = 4, release reset, run 16 cycles → o_tick at cycles 4/8/12/16; o_sec = 4; o_hour = 0, o_pm = 0 with i_h12 = 0.
- Load 23:59:58, run 2 ticks → 23:59:59, then 00:00:00 with o_day_hit = 1 for exactly that cycle; i_h12 = 1 shows o_hour = 12, o_pm = 0.
- Load 24:00:00 or 10:60:00 → o_load_err pulses once, time unchanged.
- Mode pulse, 2 pos pulses, 3 inc pulses → hour +3 mod 24, o_sel = 100, no tick; inc at sec = 59 → sec = 0, min unchanged.
- Mode, pos and inc pulses in the same cycle → only mode toggles; tick coincident with entry into SETUP → sec increments once.
- Assert rst in SETUP at 13:45:10 → next cycle 00:00:00, CLOCK, o_sel = 000, prescaler restarts from 0.
